coffee_plant_emulator: RTL and testbench
========================================

Name: coffee_plant_emulator

Overview:
- Behavioural plant/sensor responder for the coffee_making controller. It receives the controller's actuator outputs and returns the six stage sensors (mwis/mwos, ewis/ewos, cwis/cwos) with programmable fill and drain latencies.
- Used to close the loop around the controller in system benches and FPGA bring-up, replacing hand-driven sensor stimulus.
- Contains three identical stage channels: MW (milk/water mix), E (extraction), CW (cup).

Parameters:
- FILL_CYCLES, 4, cycles from a drive being sampled high to its in-sensor (*wis) asserting; legal range 1..2^CNT_W-1.
- DRAIN_CYCLES, 3, cycles from a drive being sampled low in FULL to its out-sensor (*wos) asserting; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of each channel's latency counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- p  in  1  controller power/ready; channels advance only while p=1.
- m  in  1  MW stage drive.
- w  in  1  E stage drive.
- c  in  1  CW stage drive.
- s  in  1  stir indication; ignored, no effect.
- st  in  1  start/heat indication; ignored, no effect.
- f  in  1  finish; returns all channels to IDLE.
- mwis  out  1  MW in-sensor: stage full.
- mwos  out  1  MW out-sensor: stage drained.
- ewis  out  1  E in-sensor.
- ewos  out  1  E out-sensor.
- cwis  out  1  CW in-sensor.
- cwos  out  1  CW out-sensor.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous): all channels go to IDLE, counters 0, all sensors 0, err=0.
- Outputs are registered, with no combinational path from inputs to outputs.
- Per-channel FSM, where drive means m/w/c for MW/E/CW respectively:
  - IDLE: sensors 0. If drive=1 and p=1, go to FILL with cnt=1.
  - FILL: cnt increments each cycle while drive=1 and p=1. When cnt reaches FILL_CYCLES, go to FULL.
    - Net effect: drive first sampled high at edge k gives *wis=1 after edge k+FILL_CYCLES.
    - drive=0 in FILL: abort to IDLE, cnt=0, sensors stay 0.
  - FULL: *wis=1. When drive=0, go to DRAIN with cnt=1 and *wis=0 on that same edge.
  - DRAIN: cnt increments. When cnt reaches DRAIN_CYCLES, go to DONE.
    - drive=1 in DRAIN: restart to FILL with cnt=1; *wos never asserts.
  - DONE: *wos=1, held. When drive=1 and p=1, go to FILL (*wos=0, cnt=1).
- p=0 freezes every channel's state and counter; sensors hold their values.
- f=1 forces all channels to IDLE, clears all sensors, and clears counters on the next edge. f has priority over every drive and over p.
- *wis and *wos of one channel are never both 1.
- err is set and held until reset when:
  - any of m/w/c is 1 while p=0, or
  - two or more of m/w/c are 1 in the same cycle. In this case all channels still advance independently.
- Counter width rule: a parameter value ≥ 2^CNT_W is illegal. An elaboration-time check must fail the build.
- Channels are fully independent except for the shared p, f and err.

Optional Feature:
- Macro: PLANT_STUCK_SENSOR_EN.
- Defined:
  - Adds input port stuck, 3 bits: bit0=MW, bit1=E, bit2=CW.
  - While a channel's stuck bit is 1, its *wis output is forced to 0. The channel FSM still reaches FULL internally, and *wos behaves normally.
  - Purpose: fault injection for controller timeout checks.
- Not defined: no stuck port; sensors are driven purely by the FSMs.

Test Plan:
- Reset: rst=0 for 2 cycles, with m=w=c=1 and p=1 -> all six sensors 0 and err=0 throughout; first transition only after rst=1.
- Nominal MW (defaults): p=1, m=1 first sampled at edge 10 -> mwis=1 after edge 14. m=0 sampled at edge 20 -> mwis=0 after edge 20, mwos=1 after edge 23. mwos held until f=1 at edge 30 -> mwos=0 after edge 30.
- Abort and restart: w=1 for 2 cycles, then 0 -> ewis never rises. c=1 to FULL, c=0 for 1 cycle, then c=1 -> cwos never rises; cwis returns 4 cycles later.
- Freeze and error: during MW FILL at cnt=2, p=0 for 5 cycles while m=1 -> err=1 sticky and mwis delayed by exactly 5 cycles. A later m=1 with w=1 simultaneously keeps err=1.
- f priority: channels in FULL, DRAIN and DONE plus f=1 with c=1 -> all sensors 0 next cycle, all channels IDLE; CW enters FILL only when f=0.
- PLANT_STUCK_SENSOR_EN: stuck=3'b010, w high 10 cycles -> ewis stays 0. w=0 -> ewos=1 after DRAIN_CYCLES=3 edges.

Source files
------------

// File: rtl/coffee_plant_emulator_if.sv
// Bus between the coffee_making controller and its plant emulator.
// stuck exists only when PLANT_STUCK_SENSOR_EN is defined.
interface coffee_plant_emulator_if;
  // All signals are levels sampled on every rising clock edge; there is no
  // valid/ready pairing. A drive (m/w/c) counts only on edges where p=1.
  logic       p;
  logic       m;
  logic       w;
  logic       c;
  logic       s;
  logic       st;
  logic       f;
  logic       mwis;
  logic       mwos;
  logic       ewis;
  logic       ewos;
  logic       cwis;
  logic       cwos;
  logic       err;
  logic [8:0] dbg_state;

`ifdef PLANT_STUCK_SENSOR_EN
  logic [2:0] stuck;

  modport master (
    output p, m, w, c, s, st, f, stuck,
    input  mwis, mwos, ewis, ewos, cwis, cwos, err, dbg_state
  );
  modport slave (
    input  p, m, w, c, s, st, f, stuck,
    output mwis, mwos, ewis, ewos, cwis, cwos, err, dbg_state
  );
`else
  modport master (
    output p, m, w, c, s, st, f,
    input  mwis, mwos, ewis, ewos, cwis, cwos, err, dbg_state
  );
  modport slave (
    input  p, m, w, c, s, st, f,
    output mwis, mwos, ewis, ewos, cwis, cwos, err, dbg_state
  );
`endif
endinterface

// File: rtl/coffee_plant_emulator.sv
// Plant emulator: three stage channels (MW, E, CW) answer the controller drives with
// registered in/out sensors. Optional stuck-sensor injection: PLANT_STUCK_SENSOR_EN.
module coffee_plant_emulator #(
  parameter int FILL_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input logic                    clk,
  input logic                    rst,
  coffee_plant_emulator_if.slave bus
);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (FILL_CYCLES < 1 || FILL_CYCLES > CNT_MAX) begin : g_bad_fill
    $error("FILL_CYCLES=%0d outside legal range 1..%0d", FILL_CYCLES, CNT_MAX);
  end
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > CNT_MAX) begin : g_bad_drain
    $error("DRAIN_CYCLES=%0d outside legal range 1..%0d", DRAIN_CYCLES, CNT_MAX);
  end

  localparam logic [CNT_W-1:0] FILL_LAST  = FILL_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DRAIN_LAST = DRAIN_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FULL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e           state_q [3];
  state_e           state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       wis_q, wis_d;
  logic [2:0]       wos_q, wos_d;
  logic             err_q, err_d;
  logic [2:0]       drive;
  logic [2:0]       stuck_mask;
  logic             multi_drive;
  logic             unused_inputs;

  assign drive = {bus.c, bus.w, bus.m};

`ifdef PLANT_STUCK_SENSOR_EN
  assign stuck_mask = bus.stuck;
`else
  assign stuck_mask = 3'b000;
`endif

  // Stir and heat indications carry no plant behaviour.
  assign unused_inputs = bus.s ^ bus.st;

  assign multi_drive = (drive[0] & drive[1]) | (drive[0] & drive[2]) | (drive[1] & drive[2]);
  assign err_d       = err_q | ((|drive) & ~bus.p) | multi_drive;

  always_comb begin
    wis_d = '0;
    wos_d = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (bus.f) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (bus.p) begin
        case (state_q[i])
          ST_IDLE: begin
            if (drive[i]) begin
              state_d[i] = ST_FILL;
              cnt_d[i]   = CNT_ONE;
            end
          end
          ST_FILL: begin
            if (!drive[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == FILL_LAST) begin
              state_d[i] = ST_FULL;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          ST_FULL: begin
            if (!drive[i]) begin
              state_d[i] = ST_DRAIN;
              cnt_d[i]   = CNT_ONE;
            end
          end
          ST_DRAIN: begin
            // A returning drive refills before the out-sensor can assert.
            if (drive[i]) begin
              state_d[i] = ST_FILL;
              cnt_d[i]   = CNT_ONE;
            end else if (cnt_q[i] == DRAIN_LAST) begin
              state_d[i] = ST_DONE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          ST_DONE: begin
            if (drive[i]) begin
              state_d[i] = ST_FILL;
              cnt_d[i]   = CNT_ONE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // Sensors are decoded from the next state so they flip on the same edge.
      wis_d[i] = (state_d[i] == ST_FULL) && !stuck_mask[i];
      wos_d[i] = (state_d[i] == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      wis_q <= '0;
      wos_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      wis_q <= wis_d;
      wos_q <= wos_d;
      err_q <= err_d;
    end
  end

  assign bus.mwis      = wis_q[0];
  assign bus.mwos      = wos_q[0];
  assign bus.ewis      = wis_q[1];
  assign bus.ewos      = wos_q[1];
  assign bus.cwis      = wis_q[2];
  assign bus.cwos      = wos_q[2];
  assign bus.err       = err_q;
  assign bus.dbg_state = {state_q[2], state_q[1], state_q[0]};
endmodule

// File: tb/tb_coffee_plant_emulator.sv
// Bench for coffee_plant_emulator: vector table, hand sequences and randomized
// stimulus against a timestamp-based plant model. Honours PLANT_STUCK_SENSOR_EN.
module tb_coffee_plant_emulator;
  localparam int FILL  = 4;
  localparam int DRAIN = 3;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coffee_plant_emulator_if bus ();

  coffee_plant_emulator #(
    .FILL_CYCLES (FILL),
    .DRAIN_CYCLES(DRAIN),
    .CNT_W       (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Output vector order: {err, cwos, cwis, ewos, ewis, mwos, mwis}
  typedef struct packed {
    logic       p;
    logic       m;
    logic       w;
    logic       c;
    logic       f;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl [25];
  logic [6:0] exp_q [$];
  int         n_cmp;
  int         n_bad;
  logic [2:0] stuck_v;

  // ---------------- reference model ----------------
  // Each channel remembers the active-edge timestamp at which filling or
  // draining began; sensors follow from elapsed active time.
  int         m_t;
  int         rise [3];
  int         fall [3];
  logic [2:0] m_full;
  logic [2:0] m_done;
  logic       m_err;

  task automatic model_reset();
    m_t = 0;
    m_full = '0;
    m_done = '0;
    m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = -1;
      fall[i] = -1;
    end
  endtask

  task automatic model_step(input logic p, input logic f, input logic [2:0] drv);
    if ((drv != 3'b000 && !p) || $countones(drv) >= 2) m_err = 1'b1;
    if (f) begin
      m_full = '0;
      m_done = '0;
      for (int i = 0; i < 3; i++) begin
        rise[i] = -1;
        fall[i] = -1;
      end
    end else if (p) begin
      for (int i = 0; i < 3; i++) begin
        if (drv[i]) begin
          fall[i] = -1;
          if (!m_full[i] && rise[i] < 0) begin
            rise[i] = m_t;
            m_done[i] = 1'b0;
          end else if (rise[i] >= 0 && (m_t - rise[i]) == FILL) begin
            m_full[i] = 1'b1;
            rise[i] = -1;
          end
        end else begin
          rise[i] = -1;
          if (m_full[i]) begin
            m_full[i] = 1'b0;
            fall[i] = m_t;
          end else if (fall[i] >= 0 && (m_t - fall[i]) == DRAIN) begin
            m_done[i] = 1'b1;
            fall[i] = -1;
          end
        end
      end
      m_t++;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] wis;
    wis = m_full & ~stuck_v;
    return {m_err, m_done[2], wis[2], m_done[1], wis[1], m_done[0], wis[0]};
  endfunction

  function automatic logic [6:0] dut_out();
    return {bus.err, bus.cwos, bus.cwis, bus.ewos, bus.ewis, bus.mwos, bus.mwis};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b (err,cwos,cwis,ewos,ewis,mwos,mwis)",
               name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic p, input logic m, input logic w, input logic c,
                       input logic f);
    bus.p  = p;
    bus.m  = m;
    bus.w  = w;
    bus.c  = c;
    bus.f  = f;
    bus.s  = 1'($urandom_range(0, 1));
    bus.st = 1'($urandom_range(0, 1));
`ifdef PLANT_STUCK_SENSOR_EN
    bus.stuck = stuck_v;
`endif
  endtask

  task automatic do_reset(input bit chk_async);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    if (chk_async) begin
      #1;
      check("reset_async", dut_out(), 7'b0);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", dut_out(), 7'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // One clock: apply inputs, advance the model on the edge, check at negedge.
  task automatic step(input logic p, input logic m, input logic w, input logic c,
                      input logic f);
    drive(p, m, w, c, f);
    @(posedge clk);
    model_step(p, f, {c, w, m});
    exp_q.push_back(model_out());
    @(negedge clk);
    check("model", dut_out(), exp_q.pop_front());
  endtask

  task automatic steps(input int n, input logic p, input logic m, input logic w,
                       input logic c, input logic f);
    for (int k = 0; k < n; k++) step(p, m, w, c, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] drv;
    logic [2:0] mask;
    logic       p_r;
    n_cmp = 0;
    n_bad = 0;
    stuck_v = 3'b000;

    // {p,m,w,c,f}, expected outputs after that edge
    for (int i = 0; i < 4; i++) tbl[i] = {5'b11000, 7'b0000000};
    tbl[4]  = {5'b11000, 7'b0000001};
    tbl[5]  = {5'b11000, 7'b0000001};
    for (int i = 6; i < 9; i++) tbl[i] = {5'b10000, 7'b0000000};
    tbl[9]  = {5'b10000, 7'b0000010};
    tbl[10] = {5'b10000, 7'b0000010};
    tbl[11] = {5'b00000, 7'b0000010};
    tbl[12] = {5'b10001, 7'b0000000};
    tbl[13] = {5'b10100, 7'b0000000};
    tbl[14] = {5'b10100, 7'b0000000};
    tbl[15] = {5'b10000, 7'b0000000};
    for (int i = 16; i < 20; i++) tbl[i] = {5'b10100, 7'b0000000};
    tbl[20] = {5'b10100, 7'b0000100};
    tbl[21] = {5'b10101, 7'b0000000};
    tbl[22] = {5'b10100, 7'b0000000};
    tbl[23] = {5'b00100, 7'b1000000};
    tbl[24] = {5'b11100, 7'b1000000};

    do_reset(1'b0);
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].p, tbl[i].m, tbl[i].w, tbl[i].c, tbl[i].f);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Freeze during MW fill: five frozen edges push mwis out by five.
    do_reset(1'b1);
    steps(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("freeze_err", dut_out(), 7'b1000000);
    steps(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    steps(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("freeze_not_yet", dut_out(), 7'b1000000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("freeze_mwis", dut_out(), 7'b1000001);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("err_sticky", dut_out(), 7'b1000001);

    // CW drain interrupted by a new drive: refill, no cwos.
    do_reset(1'b1);
    steps(5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cw_full", dut_out(), 7'b0010000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    steps(4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cw_no_wos", dut_out(), 7'b0000000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cw_refull", dut_out(), 7'b0010000);
    steps(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cw_drained", dut_out(), 7'b0100000);

    // f against channels in DONE, DRAIN and FULL.
    do_reset(1'b1);
    steps(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    steps(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mw_done", dut_out(), 7'b0000010);
    steps(5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ew_cw_full", dut_out(), 7'b1010110);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("e_drain", dut_out(), 7'b1010010);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("f_clear", dut_out(), 7'b1000000);
    steps(4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("f_refill_wait", dut_out(), 7'b1000000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("f_refill_full", dut_out(), 7'b1010000);

`ifdef PLANT_STUCK_SENSOR_EN
    do_reset(1'b1);
    stuck_v = 3'b010;
    steps(10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stuck_ewis", dut_out(), 7'b0000000);
    steps(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stuck_ewos", dut_out(), 7'b0001000);
    stuck_v = 3'b000;
`endif

    // Randomized: segment 0 keeps one channel active with p=1, segment 1 is free.
    for (int seg = 0; seg < 2; seg++) begin
      do_reset(1'b1);
      drv = 3'b000;
      for (int n = 0; n < 150; n++) begin
        mask = (seg == 0) ? (3'b001 << ((n / 50) % 3)) : 3'b111;
        for (int i = 0; i < 3; i++)
          if ($urandom_range(0, 5) == 0) drv[i] = ~drv[i];
        drv = drv & mask;
        p_r = (seg == 0) ? 1'b1 : 1'($urandom_range(0, 9) != 0);
`ifdef PLANT_STUCK_SENSOR_EN
        if ($urandom_range(0, 19) == 0) stuck_v = 3'($urandom_range(0, 7));
`endif
        step(p_r, drv[0], drv[1], drv[2], 1'($urandom_range(0, 49) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
